// File: rtl/trace_checker_if.sv
// Bundles the trace checker's load port, commit stream and verdict outputs.
// master drives the table and commit stream; slave is the checker itself.
interface trace_checker_if #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [PC_W-1:0]   load_pc;
    logic [DATA_W-1:0] load_result;
    logic [AW:0]       num_entries;
    logic              start;
    logic              commit;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;

    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [7:0]        err_count;
    logic [AW-1:0]     first_fail_idx;

    modport master (
        output load_en, load_addr, load_pc, load_result, num_entries, start,
        output commit, pc, result,
        input  busy, done, pass, timeout, err_count, first_fail_idx
    );

    modport slave (
        input  load_en, load_addr, load_pc, load_result, num_entries, start,
        input  commit, pc, result,
        output busy, done, pass, timeout, err_count, first_fail_idx
    );
endinterface

// File: rtl/trace_checker.sv
// Compares the core's committed pc/result stream in order against a preloaded
// expected-trace table and produces a registered pass/fail/timeout verdict.
module trace_checker #(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst_n,
    trace_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] result;
    } entry_t;

    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q;
    entry_t        tbl_q [DEPTH];
    logic [AW-1:0] idx_q;
    logic [AW-1:0] ffi_q;
    logic [AW:0]   n_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    err_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          to_q;

    entry_t        cur;
    logic          mis;
    logic          last;
    logic          gap_hit;
    logic [7:0]    err_d;
    logic [AW:0]   n_d;

    always_comb begin
        cur     = tbl_q[idx_q];
        mis     = (bus.pc != cur.pc) || (bus.result != cur.result);
        err_d   = err_q;
        if (mis && (err_q != 8'hFF))
            err_d = err_q + 8'd1;
        last    = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
        // Gap reaches TIMEOUT on this idle cycle.
        gap_hit = (gap_q == GW'(TIMEOUT - 1));
        n_d     = (bus.num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_entries;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++)
                tbl_q[i] <= '0;
            idx_q   <= '0;
            ffi_q   <= '0;
            n_q     <= '0;
            gap_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            // The table is frozen while a run is comparing against it.
            if (bus.load_en && (state_q != CHECK))
                tbl_q[bus.load_addr] <= entry_t'{pc: bus.load_pc, result: bus.load_result};

            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        idx_q <= '0;
                        ffi_q <= '0;
                        gap_q <= '0;
                        err_q <= '0;
                        to_q  <= 1'b0;
                        n_q   <= n_d;
                        if (bus.num_entries == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= CHECK;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end

                CHECK: begin
                    if (bus.commit) begin
                        err_q <= err_d;
                        if (mis && (err_q == 8'd0))
                            ffi_q <= idx_q;
                        gap_q <= '0;
                        idx_q <= idx_q + AW'(1);
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 8'd0);
                        end
                    end else if (gap_hit) begin
                        gap_q   <= gap_q + GW'(1);
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        to_q    <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.timeout        = to_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: stimulus pushes expected verdicts into a
// scoreboard queue, a negedge monitor pops one each time done rises.
module tb_trace_checker;
    localparam int DEPTH   = 16;
    localparam int PC_W    = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_prev = 1'b0;

    typedef struct {
        bit pass;
        bit to;
        int err;
        int ffi;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    trace_checker_if #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) bus();

    trace_checker #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one verdict per rising done.
    always @(negedge clk) begin
        if (rst_n && bus.done && !done_prev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pass",           int'(bus.pass),           int'(e.pass));
                chk("timeout",        int'(bus.timeout),        int'(e.to));
                chk("err_count",      int'(bus.err_count),      e.err);
                chk("first_fail_idx", int'(bus.first_fail_idx), e.ffi);
                chk("done_cycle",     cyc,                      e.cyc);
                chk("busy_at_done",   int'(bus.busy),           0);
            end
        end
        done_prev = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit p, input bit t, input int e, input int f, input int c);
        exp_t x;
        x.pass = p; x.to = t; x.err = e; x.ffi = f; x.cyc = c;
        sbq.push_back(x);
    endtask

    task automatic load(input int a, input int p, input int r);
        bus.load_en     = 1'b1;
        bus.load_addr   = 4'(a);
        bus.load_pc     = 8'(p);
        bus.load_result = 32'(r);
        tick();
        bus.load_en     = 1'b0;
    endtask

    task automatic start_run(input int n);
        bus.num_entries = 5'(n);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic do_commit(input int p, input int r);
        bus.commit = 1'b1;
        bus.pc     = 8'(p);
        bus.result = 32'(r);
        tick();
        bus.commit = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 300) begin
            tick();
            n++;
        end
        if (!bus.done) chk("wait_done_expired", 0, 1);
        tick();
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy),           0);
        chk({tag, "_done"}, int'(bus.done),           0);
        chk({tag, "_pass"}, int'(bus.pass),           0);
        chk({tag, "_to"},   int'(bus.timeout),        0);
        chk({tag, "_err"},  int'(bus.err_count),      0);
        chk({tag, "_ffi"},  int'(bus.first_fail_idx), 0);
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) load(i, 4 * i, 5 * (i + 1));
    endtask

    initial begin
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_pc = '0; bus.load_result = '0;
        bus.num_entries = '0; bus.start = 1'b0; bus.commit = 1'b0;
        bus.pc = '0; bus.result = '0;
        #2;
        reset_outputs_zero("rst");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Run 1: four matching commits back to back.
        load4();
        start_run(4);
        chk("busy_run1", int'(bus.busy), 1);
        for (int i = 0; i < 3; i++) do_commit(4 * i, 5 * (i + 1));
        do_commit(12, 20);
        push(1, 0, 0, 0, cyc);
        wait_done();
        // Commits in DONE leave the verdict alone.
        do_commit(1, 1);
        tick();
        chk("done_commit_err",  int'(bus.err_count), 0);
        chk("done_commit_pass", int'(bus.pass),      1);

        // Run 2: idle gaps between commits, entry 2 wrong.
        start_run(4);
        repeat (2) tick();
        do_commit(0, 5);
        tick();
        do_commit(4, 10);
        repeat (3) tick();
        do_commit(8, 99);
        repeat (5) tick();
        do_commit(12, 20);
        push(0, 0, 1, 2, cyc);
        wait_done();

        // Run 3: two good commits then silence.
        start_run(4);
        do_commit(0, 5);
        do_commit(4, 10);
        push(0, 1, 0, 0, cyc + TIMEOUT);
        wait_done();

        // Run 4: reset mid-run aborts without a verdict.
        start_run(4);
        do_commit(0, 5);
        do_commit(4, 10);
        rst_n = 1'b0;
        #1;
        reset_outputs_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();

        // Empty run completes immediately.
        start_run(0);
        push(1, 0, 0, 0, cyc);
        tick();
        tick();

        // Reload (entry 0 written in the start cycle); start/load during CHECK ignored.
        for (int i = 1; i < 4; i++) load(i, 4 * i, 5 * (i + 1));
        bus.load_en = 1'b1; bus.load_addr = 4'd0; bus.load_pc = 8'd0; bus.load_result = 32'd5;
        start_run(4);
        bus.load_en = 1'b0;
        do_commit(0, 5);
        bus.start = 1'b1; bus.num_entries = 5'd1;
        bus.load_en = 1'b1; bus.load_addr = 4'd3; bus.load_pc = 8'd77; bus.load_result = 32'd77;
        do_commit(4, 10);
        bus.start = 1'b0; bus.load_en = 1'b0;
        do_commit(8, 15);
        do_commit(12, 20);
        push(1, 0, 0, 0, cyc);
        wait_done();

        // Run 5: 16 entries, every one mismatched.
        for (int i = 0; i < DEPTH; i++) load(i, i, 3 * i);
        start_run(16);
        for (int i = 0; i < DEPTH; i++) do_commit(i, 3 * i + 1);
        push(0, 0, 16, 0, cyc);
        wait_done();

        // Run 6: no reload, oversize num_entries clamps; only 5 and 9 wrong.
        start_run(31);
        for (int i = 0; i < DEPTH; i++) do_commit(i, (i == 5 || i == 9) ? 3 * i + 2 : 3 * i);
        push(0, 0, 2, 5, cyc);
        wait_done();

        repeat (4) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
